// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: program sequencer feeding 10-bit PI words to the 5-bit CPU.
// Loads a small program memory while idle, then issues instructions in order
// on a valid/ready handshake and captures the CPU result and flags on each
// accepted instruction.
// Optional build macro SEQ_STEP_EN: adds a 'step' input; each step pulse arms
// exactly one handshake.
//
// state | meaning
// IDLE  | waiting for start; program memory writable
// PREP  | synchronous read of mem[pc] into pi_out
// ISSUE | pi_out offered to the CPU until accepted
// DONE  | one-cycle done pulse, then back to IDLE
module instr_fetch_seq #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [IW-1:0] ld_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
`ifdef SEQ_STEP_EN
  input  logic          step,
`endif
  output logic [IW-1:0] pi_out,
  output logic          pi_valid,
  input  logic          pi_ready,
  input  logic [4:0]    r_in,
  input  logic          cf_in,
  input  logic          sf_in,
  input  logic          zf_in,
  input  logic          gf_in,
  output logic [4:0]    r_q,
  output logic [3:0]    flags_q,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [7:0]    icount
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PREP  = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_e        state_q;
  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] pc_q;
  logic [AW:0]   len_q;
  logic [IW-1:0] pi_out_q;
  logic          pi_valid_q;
  logic [4:0]    result_q;
  logic [3:0]    flag_q;
  logic          busy_q;
  logic          done_q;
  logic [7:0]    icount_q;

  logic [AW:0]   len_d;
  logic [7:0]    icount_d;
  logic          last_w;
  logic          valid_w;
  logic          hs_w;

  // Length clamp keeps pc inside the memory; saturating count; last-address test
  always_comb begin
    len_d    = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    icount_d = (icount_q == 8'hFF) ? icount_q : icount_q + 8'd1;
    last_w   = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));
  end

`ifdef SEQ_STEP_EN
  logic arm_q;

  // A step pulse arms one handshake; an early pulse stays armed until used
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_q <= 1'b0;
    end else begin
      arm_q <= (arm_q & ~hs_w) | step;
    end
  end

  assign valid_w = pi_valid_q & arm_q;
`else
  assign valid_w = pi_valid_q;
`endif

  assign hs_w = valid_w & pi_ready;

  // Program memory: written only while idle, never reset
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_IDLE && ld_we) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      len_q      <= '0;
      pi_out_q   <= '0;
      pi_valid_q <= 1'b0;
      result_q   <= '0;
      flag_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      icount_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && prog_len != '0) begin
            state_q  <= S_PREP;
            pc_q     <= '0;
            icount_q <= '0;
            len_q    <= len_d;
            busy_q   <= 1'b1;
          end
        end
        S_PREP: begin
          pi_out_q   <= mem[pc_q];
          pi_valid_q <= 1'b1;
          state_q    <= S_ISSUE;
        end
        S_ISSUE: begin
          if (hs_w) begin
            result_q   <= r_in;
            flag_q     <= {gf_in, zf_in, sf_in, cf_in};
            icount_q   <= icount_d;
            pi_valid_q <= 1'b0;
            if (last_w) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              pc_q    <= pc_q + AW'(1);
              state_q <= S_PREP;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pi_out   = pi_out_q;
  assign pi_valid = valid_w;
  assign r_q      = result_q;
  assign flags_q  = flag_q;
  assign pc       = pc_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign icount   = icount_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: table of program runs plus randomized runs,
// checked against a queue-based handshake model, and hand-written reset and
// step sequences.
module tb_instr_fetch_seq;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int IW    = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [IW-1:0] ld_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic [IW-1:0] pi_out;
  logic          pi_valid;
  logic          pi_ready;
  logic [4:0]    r_in;
  logic          cf_in, sf_in, zf_in, gf_in;
  logic [4:0]    r_q;
  logic [3:0]    flags_q;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic [7:0]    icount;
`ifdef SEQ_STEP_EN
  logic          step;
`endif

  always #5 clk = ~clk;

  instr_fetch_seq #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .prog_len(prog_len), .start(start),
`ifdef SEQ_STEP_EN
    .step(step),
`endif
    .pi_out(pi_out), .pi_valid(pi_valid), .pi_ready(pi_ready), .r_in(r_in),
    .cf_in(cf_in), .sf_in(sf_in), .zf_in(zf_in), .gf_in(gf_in),
    .r_q(r_q), .flags_q(flags_q), .pc(pc), .busy(busy), .done(done),
    .icount(icount)
  );

  typedef struct {
    int          plen;
    int          mode;      // 0: ready high, 1: stall 2nd instr 4 cycles, 2: random
    bit          ldw;       // write mem[0] in the same cycle as start
    logic [IW-1:0] ldw_data;
    int          exp_icnt;  // icount expected once the run has finished
  } vec_t;

  vec_t tbl[8];

  int n_vec = 0;
  int n_err = 0;

  logic [IW-1:0] mem_m [DEPTH];
  logic [4:0]    exp_r  = '0;
  logic [3:0]    exp_f  = '0;
  logic [7:0]    exp_ic = '0;

  logic [4:0] rv [3] = '{5'h08, 5'h00, 5'h1F};
  logic [3:0] fv [3] = '{4'h1, 4'h4, 4'hA};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic load(input int a, input logic [IW-1:0] d);
    @(negedge clk);
    ld_we   = 1'b1;
    ld_addr = a[AW-1:0];
    ld_data = d;
    mem_m[a] = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic run_prog(input int plen, input int mode, input bit ldw,
                          input logic [IW-1:0] ldw_data, input int exp_icnt);
    logic [IW-1:0] q[$];
    int  n, issued, stall;
    bit  prev_wait, got_done;
    @(negedge clk);
    if (ldw) begin
      ld_we = 1'b1; ld_addr = '0; ld_data = ldw_data; mem_m[0] = ldw_data;
    end
    prog_len = plen[AW:0];
    start    = 1'b1;
    n = (plen > DEPTH) ? DEPTH : plen;
    for (int i = 0; i < n; i++) q.push_back(mem_m[i]);
    if (n == 0) begin
      @(negedge clk);
      start = 1'b0; ld_we = 1'b0;
      for (int c = 0; c < 6; c++) begin
        chk("zero_busy", busy, 0);
        chk("zero_done", done, 0);
        chk("zero_valid", pi_valid, 0);
        chk("zero_icount", icount, exp_ic);
        @(negedge clk);
      end
    end else begin
      exp_ic = '0; issued = 0; stall = 0; prev_wait = 0; got_done = 0;
      for (int cyc = 1; cyc <= 300 && !got_done; cyc++) begin
        @(negedge clk);
        start = 1'b0; ld_we = 1'b0;
        chk("r_q", r_q, exp_r);
        chk("flags_q", flags_q, exp_f);
        chk("icount", icount, exp_ic);
        if (done) begin
          got_done = 1;
          chk("done_issued", issued, n);
          chk("pc_last", pc, n - 1);
          chk("busy_at_done", busy, 0);
          if (mode == 0) chk("done_latency", cyc, 2 * n + 1);
        end else begin
          chk("busy", busy, 1);
          chk("pc", pc, issued);
          if (prev_wait) chk("valid_hold", pi_valid, 1);
          if (mode == 0) chk("valid_rhythm", pi_valid, (cyc % 2) == 0);
          case (mode)
            0: pi_ready = 1'b1;
            1: begin
              pi_ready = !(issued == 1 && pi_valid && stall < 4);
              if (issued == 1 && pi_valid && !pi_ready) stall++;
            end
            default: pi_ready = 1'($urandom_range(0, 1));
          endcase
          if (mode != 2 && issued < 3) begin
            r_in = rv[issued];
            {gf_in, zf_in, sf_in, cf_in} = fv[issued];
          end else begin
            r_in = 5'($urandom);
            {gf_in, zf_in, sf_in, cf_in} = 4'($urandom);
          end
          if (pi_valid) chk("pi_out", pi_out, q[0]);
          if (pi_valid && pi_ready) begin
            exp_r = r_in;
            exp_f = {gf_in, zf_in, sf_in, cf_in};
            void'(q.pop_front());
            issued++;
            if (exp_ic != 8'hFF) exp_ic++;
          end
          prev_wait = pi_valid && !pi_ready;
          if (mode == 2) begin
            start    = 1'($urandom_range(0, 1));
            ld_we    = 1'($urandom_range(0, 1));
            ld_addr  = AW'($urandom);
            ld_data  = IW'($urandom);
            prog_len = (AW+1)'($urandom);
          end
        end
      end
      if (!got_done) chk("timeout_done", 0, 1);
      if (mode == 1) chk("stall_cycles", stall, 4);
    end
    if (exp_icnt >= 0) chk("final_icount", icount, exp_icnt);
    start = 1'b0; ld_we = 1'b0; pi_ready = 1'b0; prog_len = '0;
  endtask

  initial begin
    rst = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0; prog_len = '0;
    start = 1'b0; pi_ready = 1'b0; r_in = '0;
    cf_in = 1'b0; sf_in = 1'b0; zf_in = 1'b0; gf_in = 1'b0;
`ifdef SEQ_STEP_EN
    step = 1'b1;
`endif

    tbl[0] = '{plen: 3,  mode: 0, ldw: 0, ldw_data: '0,     exp_icnt: 3};
    tbl[1] = '{plen: 3,  mode: 1, ldw: 0, ldw_data: '0,     exp_icnt: 3};
    tbl[2] = '{plen: 0,  mode: 0, ldw: 0, ldw_data: '0,     exp_icnt: 3};
    tbl[3] = '{plen: 31, mode: 0, ldw: 0, ldw_data: '0,     exp_icnt: 16};
    tbl[4] = '{plen: 16, mode: 2, ldw: 0, ldw_data: '0,     exp_icnt: 16};
    tbl[5] = '{plen: 5,  mode: 2, ldw: 0, ldw_data: '0,     exp_icnt: 5};
    tbl[6] = '{plen: 1,  mode: 0, ldw: 1, ldw_data: 10'h2AA, exp_icnt: 1};
    tbl[7] = '{plen: 16, mode: 0, ldw: 0, ldw_data: '0,     exp_icnt: 16};

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", pi_valid, 0);
    chk("rst_pi_out", pi_out, 0);
    chk("rst_r_q", r_q, 0);
    chk("rst_flags", flags_q, 0);
    chk("rst_pc", pc, 0);
    chk("rst_done", done, 0);
    chk("rst_icount", icount, 0);
    rst = 1'b0;

    load(0, 10'h0A3); load(1, 10'h1C4); load(2, 10'h3FF);

    for (int i = 0; i < 8; i++) begin
      if (i == 3) for (int a = 0; a < DEPTH; a++) load(a, IW'($urandom));
      run_prog(tbl[i].plen, tbl[i].mode, tbl[i].ldw, tbl[i].ldw_data, tbl[i].exp_icnt);
      if (i == 0) begin
        chk("final_r_q", r_q, 5'h1F);
        chk("final_flags", flags_q, 4'hA);
      end
    end

    for (int k = 0; k < 8; k++) begin
      run_prog($urandom_range(0, 31), 2, 0, '0, -1);
    end

    // Reset while the second instruction is being offered
    load(0, 10'h0A3); load(1, 10'h1C4); load(2, 10'h3FF);
    @(negedge clk);
    prog_len = 5'd3; start = 1'b1; pi_ready = 1'b1;
    begin
      bit hit = 0;
      for (int c = 0; c < 30 && !hit; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (pi_valid && pc == 4'd1) hit = 1;
      end
      if (!hit) chk("timeout_2nd_issue", 0, 1);
    end
    pi_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", pi_valid, 0);
    chk("mid_rst_r_q", r_q, 0);
    chk("mid_rst_flags", flags_q, 0);
    chk("mid_rst_icount", icount, 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_pi_out", pi_out, 0);
    exp_r = '0; exp_f = '0; exp_ic = '0;
    run_prog(3, 0, 0, '0, 3);

`ifdef SEQ_STEP_EN
    // One handshake per step pulse
    rst = 1'b1; step = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    prog_len = 5'd3; start = 1'b1; pi_ready = 1'b1;
    begin
      int hs_cnt, done_cnt;
      done_cnt = 0;
      for (int k = 0; k < 3; k++) begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          start = 1'b0;
          chk("step_no_valid", pi_valid, 0);
        end
        step = 1'b1;
        hs_cnt = 0;
        for (int c = 0; c < 6; c++) begin
          @(negedge clk);
          step = 1'b0;
          if (pi_valid) begin
            chk("step_pi_out", pi_out, mem_m[k]);
            hs_cnt++;
          end
          if (done) done_cnt++;
        end
        chk("step_handshakes", hs_cnt, 1);
      end
      chk("step_done", done_cnt, 1);
      chk("step_icount", icount, 3);
    end
    pi_ready = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
